// File: rtl/dac_update_sched_if.sv
// Sample stream into the DAC update scheduler: valid/ready handshake carrying
// signed two's-complement samples.
interface dac_update_sched_if #(
  parameter int IN_WIDTH = 24
) ();
  logic                       in_valid;
  logic                       in_ready;
  logic signed [IN_WIDTH-1:0] in_data;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/dac_update_sched.sv
// Buffers signed samples, converts them to rounded/saturated offset-binary
// DAC codes and paces strobes to the serial DAC transaction rate.
module dac_update_sched #(
  parameter  int IN_WIDTH   = 24,
  parameter  int DAC_BITS   = 16,
  parameter  int FIFO_DEPTH = 4,
  parameter  int MIN_GAP    = 2,
  localparam int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                enable,
  input  logic                mute,
  input  logic                sat_clr,
  dac_update_sched_if.slave   s_in,
  output logic                strobe_out,
  output logic [DAC_BITS-1:0] data_out,
  output logic                busy,
  output logic [LVL_W-1:0]    fifo_level,
  output logic                sat_flag
);

  localparam int SHIFT   = IN_WIDTH - DAC_BITS;
  localparam int HOLDOFF = 2 * DAC_BITS + 1 + MIN_GAP;
  localparam int CNT_W   = $clog2(HOLDOFF);
  localparam int PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  localparam logic [DAC_BITS-1:0]      MIDSCALE = {1'b1, {(DAC_BITS-1){1'b0}}};
  localparam logic signed [IN_WIDTH:0] HALF_LSB = (IN_WIDTH+1)'(1) <<< (SHIFT - 1);
  localparam logic signed [IN_WIDTH:0] Q_MAX    = (IN_WIDTH+1)'((1 << (DAC_BITS - 1)) - 1);

  // Returns {saturated, offset-binary code}; rounds half-up, clips the top only.
  function automatic logic [DAC_BITS:0] round_sat(input logic signed [IN_WIDTH-1:0] x);
    logic signed [IN_WIDTH:0] r;
    logic signed [IN_WIDTH:0] q;
    logic [DAC_BITS-1:0]      c;
    logic                     sat;
    r   = {x[IN_WIDTH-1], x};
    r   = r + HALF_LSB;
    q   = r >>> SHIFT;
    sat = (q > Q_MAX);
    c   = sat ? Q_MAX[DAC_BITS-1:0] : q[DAC_BITS-1:0];
    return {sat, ~c[DAC_BITS-1], c[DAC_BITS-2:0]};
  endfunction

  logic signed [IN_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]           r_wr_ptr;
  logic [PTR_W-1:0]           r_rd_ptr;
  logic [LVL_W-1:0]           r_level;
  logic [CNT_W-1:0]           r_cnt;
  logic                       r_strobe_p1;
  logic [DAC_BITS-1:0]        r_data_p1;
  logic                       r_sat;

  logic                       w_full;
  logic                       w_push;
  logic                       w_pop;
  logic [DAC_BITS:0]          w_conv;
  logic                       w_sat_set;

  assign w_full    = (r_level == LVL_W'(FIFO_DEPTH));
  assign w_push    = s_in.in_valid && !w_full;
  // A zero holdoff count is the slot in which the next word may be popped.
  assign w_pop     = enable && (r_level != '0) && (r_cnt == '0);
  assign w_conv    = round_sat(r_mem[r_rd_ptr]);
  assign w_sat_set = w_pop && !mute && w_conv[DAC_BITS];

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= s_in.in_data;
  end

  // Stage p0 -> p1: pop, convert and register the strobe with its code
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_level     <= '0;
      r_cnt       <= '0;
      r_strobe_p1 <= 1'b0;
      r_data_p1   <= MIDSCALE;
      r_sat       <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      unique case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LVL_W'(1);
        2'b01:   r_level <= r_level - LVL_W'(1);
        default: r_level <= r_level;
      endcase
      if (w_pop)              r_cnt <= CNT_W'(HOLDOFF - 1);
      else if (r_cnt != '0)   r_cnt <= r_cnt - CNT_W'(1);
      r_strobe_p1 <= w_pop;
      if (w_pop) r_data_p1 <= mute ? MIDSCALE : w_conv[DAC_BITS-1:0];
      r_sat <= w_sat_set | (r_sat & ~sat_clr);
    end
  end

  assign s_in.in_ready = !w_full;
  assign strobe_out    = r_strobe_p1;
  assign data_out      = r_data_p1;
  assign busy          = (r_cnt != '0);
  assign fifo_level    = r_level;
  assign sat_flag      = r_sat;

endmodule

// File: tb/tb_dac_update_sched.sv
// Randomized and directed bench for dac_update_sched against a queue-based
// reference model of the scheduling and conversion rules.
module tb_dac_update_sched;
  localparam int IN_WIDTH   = 24;
  localparam int DAC_BITS   = 16;
  localparam int FIFO_DEPTH = 4;
  localparam int MIN_GAP    = 2;
  localparam int HOLDOFF    = 2 * DAC_BITS + 1 + MIN_GAP;
  localparam int LVL_W      = $clog2(FIFO_DEPTH) + 1;
  localparam logic [DAC_BITS-1:0] MID = 16'h8000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                reset_n, enable, mute, sat_clr;
  logic                strobe_out, busy, sat_flag;
  logic [DAC_BITS-1:0] data_out;
  logic [LVL_W-1:0]    fifo_level;

  dac_update_sched_if #(.IN_WIDTH(IN_WIDTH)) u_if ();

  dac_update_sched #(
    .IN_WIDTH(IN_WIDTH), .DAC_BITS(DAC_BITS), .FIFO_DEPTH(FIFO_DEPTH), .MIN_GAP(MIN_GAP)
  ) u_dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .mute(mute), .sat_clr(sat_clr),
    .s_in(u_if), .strobe_out(strobe_out), .data_out(data_out), .busy(busy),
    .fifo_level(fifo_level), .sat_flag(sat_flag)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", tag, obs, exp, cyc);
    end
  endtask

  // Reference model state
  int                  mq[$];
  logic [DAC_BITS-1:0] m_data   = MID;
  bit                  m_strobe = 0;
  bit                  m_sat    = 0;
  longint              cyc      = 0;
  longint              last_s   = -1000;

  // Observation state
  logic [DAC_BITS-1:0] slog[$];
  longint              gaps[$];
  longint              dut_last = -1;
  longint              first_strobe = -1;
  int                  busy_cnt = 0;
  int                  cs_rem = 0, hi_run = 100;
  bit                  ser_prev = 0;

  function automatic logic [DAC_BITS:0] ref_conv(input int x);
    longint sh, v, q, qmax;
    sh   = IN_WIDTH - DAC_BITS;
    qmax = (longint'(1) << (DAC_BITS - 1)) - 1;
    v    = longint'(x) + (longint'(1) << (sh - 1));
    if (v >= 0) q = v / (longint'(1) << sh);
    else        q = -((-v + (longint'(1) << sh) - 1) / (longint'(1) << sh));
    if (q > qmax) return {1'b1, DAC_BITS'(qmax + (longint'(1) << (DAC_BITS - 1)))};
    return {1'b0, DAC_BITS'(q + (longint'(1) << (DAC_BITS - 1)))};
  endfunction

  task automatic cycle(input bit v, input logic [IN_WIDTH-1:0] d, input bit en,
                       input bit mu, input bit clr, input bit rn, output bit accepted);
    logic [DAC_BITS-1:0] n_data;
    logic [DAC_BITS:0]   r;
    bit                  n_strobe, n_sat, set;
    int                  sz0, x;
    u_if.in_valid = v;
    u_if.in_data  = d;
    enable = en; mute = mu; sat_clr = clr; reset_n = rn;
    accepted = 0;
    if (!rn) begin
      mq.delete();
      n_data = MID; n_strobe = 0; n_sat = 0; last_s = -1000;
    end else begin
      sz0 = mq.size();
      n_strobe = 0; n_data = m_data; set = 0;
      if (en && sz0 > 0 && (cyc + 1 - last_s >= HOLDOFF)) begin
        x = mq.pop_front();
        n_strobe = 1;
        last_s = cyc + 1;
        if (mu) n_data = MID;
        else begin
          r = ref_conv(x);
          n_data = r[DAC_BITS-1:0];
          set = r[DAC_BITS];
        end
      end
      if (v && sz0 < FIFO_DEPTH) begin
        mq.push_back($signed(d));
        accepted = 1;
      end
      n_sat = set ? 1'b1 : (clr ? 1'b0 : m_sat);
    end
    @(posedge clk);
    #1;
    cyc++;
    m_data = n_data; m_strobe = n_strobe; m_sat = n_sat;
    check("strobe", strobe_out, m_strobe);
    check("data", data_out, m_data);
    check("level", fifo_level, mq.size());
    check("in_ready", u_if.in_ready, mq.size() < FIFO_DEPTH);
    check("busy", busy, (cyc - last_s >= 0) && (cyc - last_s <= HOLDOFF - 2));
    check("sat_flag", sat_flag, m_sat);
    if (busy) busy_cnt++;
    if (!rn) begin
      ser_prev = 0; cs_rem = 0; dut_last = -1;
    end else if (strobe_out) begin
      if (ser_prev) check("cs_gap", hi_run >= MIN_GAP, 1);
      ser_prev = 1; cs_rem = 2 * DAC_BITS; hi_run = 0;
      slog.push_back(data_out);
      if (dut_last >= 0) gaps.push_back(cyc - dut_last);
      dut_last = cyc;
      if (first_strobe < 0) first_strobe = cyc;
    end else if (cs_rem > 0) cs_rem--;
    else hi_run++;
  endtask

  task automatic idle(input int n, input bit en);
    bit a;
    for (int i = 0; i < n; i++) cycle(0, '0, en, 0, 0, 1, a);
  endtask

  task automatic push(input logic [IN_WIDTH-1:0] d, input bit en, input bit mu);
    bit a;
    a = 0;
    for (int i = 0; i < 200 && !a; i++) cycle(1, d, en, mu, 0, 1, a);
    if (!a) check("push_timeout", 0, 1);
  endtask

  initial begin
    bit a;
    logic [IN_WIDTH-1:0] d;
    longint t_push;
    for (int i = 0; i < 3; i++) cycle(0, '0, 0, 0, 0, 0, a);
    check("rst_data", data_out, MID);
    check("rst_level", fifo_level, 0);
    check("rst_ready", u_if.in_ready, 1);

    // Rounding of small values
    slog.delete();
    push(24'h000000, 1, 0); push(24'h000180, 1, 0);
    push(24'h00017F, 1, 0); push(24'hFFFF80, 1, 0);
    idle(160, 1);
    check("t1_count", slog.size(), 4);
    if (slog.size() == 4) begin
      check("t1_w0", slog[0], 16'h8000); check("t1_w1", slog[1], 16'h8002);
      check("t1_w2", slog[2], 16'h8001); check("t1_w3", slog[3], 16'h8000);
    end
    check("t1_sat", sat_flag, 0);

    // Extremes and sticky saturation
    slog.delete();
    push(24'h7FFFFF, 1, 0); idle(40, 1);
    push(24'h800000, 1, 0); idle(40, 1);
    check("t2_count", slog.size(), 2);
    if (slog.size() == 2) begin
      check("t2_max", slog[0], 16'hFFFF); check("t2_min", slog[1], 16'h0000);
    end
    check("t2_sat_set", sat_flag, 1);
    cycle(0, '0, 1, 0, 1, 1, a);
    check("t2_sat_clr", sat_flag, 0);

    // Backlog: strobes exactly HOLDOFF apart
    gaps.delete(); dut_last = -1;
    for (int i = 0; i < 6; i++) push(IN_WIDTH'(i * 1000), 1, 0);
    idle(250, 1);
    check("t3_gaps", gaps.size(), 5);
    foreach (gaps[i]) check("t3_spacing", 32'(gaps[i]), HOLDOFF);

    // Single-sample latency and busy window
    first_strobe = -1;
    t_push = cyc;
    cycle(1, 24'h001234, 1, 0, 0, 1, a);
    busy_cnt = 0; slog.delete();
    idle(60, 1);
    check("t4_latency", 32'(first_strobe - t_push), 2);
    check("t4_busy_len", busy_cnt, HOLDOFF - 1);
    check("t4_one_strobe", slog.size(), 1);

    // Enable low holds the queue
    slog.delete();
    for (int i = 0; i < 3; i++) push(IN_WIDTH'(24'h020000 + i), 0, 0);
    idle(50, 0);
    check("t5_no_strobe", slog.size(), 0);
    check("t5_level", fifo_level, 3);
    gaps.delete(); dut_last = -1;
    idle(2, 1);
    check("t5_resume", slog.size(), 1);
    idle(100, 1);
    check("t5_gaps", gaps.size(), 2);
    foreach (gaps[i]) check("t5_spacing", 32'(gaps[i]), HOLDOFF);

    // Mute replaces a saturating sample
    slog.delete();
    push(24'h7FFFFF, 0, 0);
    for (int i = 0; i < 4; i++) cycle(0, '0, 1, 1, 0, 1, a);
    idle(40, 1);
    check("t6_count", slog.size(), 1);
    if (slog.size() == 1) check("t6_mid", slog[0], MID);
    check("t6_sat", sat_flag, 0);

    // Reset mid-holdoff with two queued
    for (int i = 0; i < 3; i++) push(24'h123456, 1, 0);
    idle(8, 1);
    check("t7_pre_level", fifo_level, 2);
    cycle(0, '0, 1, 0, 0, 0, a);
    check("t7_level", fifo_level, 0);
    check("t7_busy", busy, 0);
    check("t7_data", data_out, MID);
    slog.delete();
    idle(40, 1);
    check("t7_no_strobe", slog.size(), 0);

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      case ($urandom_range(0, 7))
        0:       d = 24'h7FFFFF;
        1:       d = 24'h800000;
        2:       d = IN_WIDTH'($urandom_range(0, 511)) - 24'd256;
        default: d = IN_WIDTH'($urandom);
      endcase
      cycle($urandom_range(0, 3) != 0, d, $urandom_range(0, 9) != 0,
            $urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0,
            $urandom_range(0, 499) != 0, a);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
